// File: rtl/muldiv_seq_pkg.sv
// Shared core types for the iterative multiply/divide sequencer.
// Holds the operation, adder-op and sequencer-state encodings.
package muldiv_seq_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = MD_WIDTH;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } mdOp_t;

    typedef enum logic {
        ADDER_ADD = 1'b0,
        ADDER_SUB = 1'b1
    } adderOp_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        ITER   = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } muldivState_t;

    function automatic logic md_is_div(input mdOp_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_is_rem(input mdOp_t op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic md_a_signed(input mdOp_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_b_signed(input mdOp_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

    // Upper-half products and remainders live in the hi register.
    function automatic logic md_res_hi(input mdOp_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_MULHU, MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer sharing the core adder.
// Shift-add multiply and restoring divide, one adder use per cycle.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH     = MD_WIDTH,
    parameter bit DIV0_FAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             req_valid,
    output logic             req_ready,
    input  mdOp_t            req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             add_req,
    input  logic             add_gnt,
    output adderOp_t         add_op,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldivState_t     r_state;
    mdOp_t            r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_cnt;
    logic             r_sa;
    logic             r_sb;
    logic             r_dz;
    logic             r_b0;

    muldivState_t     w_nxt_state;
    mdOp_t            w_nxt_op;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;
    logic [WIDTH-1:0] w_nxt_m;
    logic [CW-1:0]    w_nxt_cnt;
    logic             w_nxt_sa;
    logic             w_nxt_sb;
    logic             w_nxt_dz;
    logic             w_nxt_b0;

    logic             w_req_div;
    logic             w_req_bz;
    logic             w_sa;
    logic             w_sb;
    logic             w_is_mul;
    logic             w_is_rem;
    logic             w_mulh;
    logic             w_neg;
    logic             w_step;
    logic             w_qbit;
    logic [WIDTH-1:0] w_shr;

    assign w_req_div = md_is_div(req_op);
    assign w_req_bz  = (req_b == '0);
    assign w_sa      = md_a_signed(req_op) & req_a[WIDTH-1];
    assign w_sb      = md_b_signed(req_op) & req_b[WIDTH-1];

    assign w_is_mul  = ~md_is_div(r_op);
    assign w_is_rem  = md_is_rem(r_op);
    assign w_mulh    = r_op inside {MD_MULH, MD_MULHSU};
    // A zero divisor keeps the all-ones quotient unsigned.
    assign w_neg     = w_is_rem ? r_sa : ((r_sa ^ r_sb) & ~r_dz);
    assign w_shr     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);

    always_comb begin
        resp_data = '0;
        if (r_state == DONE) begin
            resp_data = md_res_hi(r_op) ? r_hi : r_lo;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_op    = r_op;
        w_nxt_hi    = r_hi;
        w_nxt_lo    = r_lo;
        w_nxt_m     = r_m;
        w_nxt_cnt   = r_cnt;
        w_nxt_sa    = r_sa;
        w_nxt_sb    = r_sb;
        w_nxt_dz    = r_dz;
        w_nxt_b0    = r_b0;
        add_req     = 1'b0;
        add_op      = ADDER_ADD;
        add_a       = '0;
        add_b       = '0;
        w_step      = 1'b0;
        w_qbit      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_nxt_op  = req_op;
                    w_nxt_sa  = w_sa;
                    w_nxt_sb  = w_sb;
                    w_nxt_dz  = w_req_div & w_req_bz;
                    w_nxt_b0  = 1'b0;
                    w_nxt_cnt = '0;
                    w_nxt_hi  = '0;
                    w_nxt_lo  = w_req_div ? req_a : req_b;
                    w_nxt_m   = w_req_div ? req_b : req_a;
                    if (DIV0_FAST && w_req_div && w_req_bz) begin
                        w_nxt_hi    = req_a;
                        w_nxt_lo    = '1;
                        w_nxt_state = DONE;
                    end else if (w_sa) begin
                        w_nxt_state = NEG_A;
                    end else if (w_sb) begin
                        w_nxt_state = NEG_B;
                    end else begin
                        w_nxt_state = ITER;
                    end
                end
            end
            // Operand a sits in r_m for multiply, r_lo for divide.
            NEG_A: begin
                add_req = 1'b1;
                add_op  = ADDER_SUB;
                add_b   = w_is_mul ? r_m : r_lo;
                if (add_gnt) begin
                    if (w_is_mul) w_nxt_m = add_out;
                    else          w_nxt_lo = add_out;
                    w_nxt_cnt   = '0;
                    w_nxt_state = r_sb ? NEG_B : ITER;
                end
            end
            NEG_B: begin
                add_req = 1'b1;
                add_op  = ADDER_SUB;
                add_b   = w_is_mul ? r_lo : r_m;
                if (add_gnt) begin
                    if (w_is_mul) w_nxt_lo = add_out;
                    else          w_nxt_m = add_out;
                    w_nxt_cnt   = '0;
                    w_nxt_state = ITER;
                end
            end
            ITER: begin
                if (w_is_mul) begin
                    if (r_lo[0]) begin
                        add_req = 1'b1;
                        add_a   = r_hi;
                        add_b   = r_m;
                        if (add_gnt) begin
                            {w_nxt_hi, w_nxt_lo} =
                                {~add_cout, add_out, r_lo[WIDTH-1:1]};
                            w_step = 1'b1;
                        end
                    end else begin
                        {w_nxt_hi, w_nxt_lo} =
                            {1'b0, r_hi, r_lo[WIDTH-1:1]};
                        w_step = 1'b1;
                    end
                end else begin
                    add_req = 1'b1;
                    add_op  = ADDER_SUB;
                    add_a   = w_shr;
                    add_b   = r_m;
                    if (add_gnt) begin
                        w_qbit   = r_hi[WIDTH-1] | ~add_cout;
                        w_nxt_hi = w_qbit ? add_out : w_shr;
                        w_nxt_lo = {r_lo[WIDTH-2:0], w_qbit};
                        w_step   = 1'b1;
                    end
                end
            end
            NEG_LO: begin
                add_req = 1'b1;
                add_op  = ADDER_SUB;
                add_b   = r_lo;
                if (add_gnt) begin
                    w_nxt_lo    = add_out;
                    w_nxt_b0    = add_cout;
                    w_nxt_state = w_mulh ? NEG_HI : DONE;
                end
            end
            // A nonzero low word absorbs the +1 of the 64-bit negate.
            NEG_HI: begin
                add_req = 1'b1;
                if (r_b0) begin
                    add_op = ADDER_ADD;
                    add_a  = ~r_hi;
                end else begin
                    add_op = ADDER_SUB;
                    add_b  = r_hi;
                end
                if (add_gnt) begin
                    w_nxt_hi    = add_out;
                    w_nxt_state = DONE;
                end
            end
            DONE: begin
                if (resp_ready) w_nxt_state = IDLE;
            end
            default: w_nxt_state = IDLE;
        endcase
        if (w_step) begin
            w_nxt_cnt = r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                if (!w_neg)        w_nxt_state = DONE;
                else if (w_is_rem) w_nxt_state = NEG_HI;
                else               w_nxt_state = NEG_LO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || kill) begin
            r_state <= IDLE;
            r_op    <= MD_MUL;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_b0    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_op    <= w_nxt_op;
            r_hi    <= w_nxt_hi;
            r_lo    <= w_nxt_lo;
            r_m     <= w_nxt_m;
            r_cnt   <= w_nxt_cnt;
            r_sa    <= w_nxt_sa;
            r_sb    <= w_nxt_sb;
            r_dz    <= w_nxt_dz;
            r_b0    <= w_nxt_b0;
        end
    end

endmodule
